// File: rtl/control_unit.sv
// control_unit: multi-cycle accumulator CPU sequencer; registered state, combinational datapath controls.
module control_unit (
  input  logic       clk,
  input  logic       clear,
  input  logic [2:0] IR75,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       in_valid,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic [1:0] Asel,
  output logic       in_ack,
  output logic       halted,
  output logic [3:0] state,
  output logic [7:0] instr_count
);
  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd8,
    S_STORE  = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_INPUT  = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = 2'b00;
    in_ack  = 1'b0;
    halted  = 1'b0;
    Meminst = state_q[3];
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH: begin
        IRload  = 1'b1;
        PCload  = 1'b1;
        state_d = S_DECODE;
        cnt_d   = cnt_q + 8'd1;
      end
      S_DECODE: begin
        Meminst = 1'b1;
        state_d = state_t'({1'b1, IR75});
      end
      S_LOAD: begin
        Aload   = 1'b1;
        Asel    = 2'b10;
        state_d = S_FETCH;
      end
      S_STORE: begin
        MemWr   = 1'b1;
        state_d = S_FETCH;
      end
      S_ADD: begin
        Aload   = 1'b1;
        state_d = S_FETCH;
      end
      S_SUB: begin
        Aload   = 1'b1;
        Sub     = 1'b1;
        state_d = S_FETCH;
      end
      S_INPUT: begin
        Aload   = in_valid;
        Asel    = in_valid ? 2'b01 : 2'b00;
        in_ack  = in_valid;
        state_d = in_valid ? S_FETCH : S_INPUT;
      end
      S_JZ: begin
        PCload  = Aeq0;
        JMPmux  = Aeq0;
        state_d = S_FETCH;
      end
      S_JPOS: begin
        PCload  = Apos;
        JMPmux  = Apos;
        state_d = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      default:  state_d = S_START;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_START;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign state       = state_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of the control_unit sequencer, one task per scenario.
module tb_control_unit;
  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] IR75 = 3'd0;
  logic       Aeq0 = 1'b0;
  logic       Apos = 1'b0;
  logic       in_valid = 1'b0;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, in_ack, halted;
  logic [1:0] Asel;
  logic [3:0] state;
  logic [7:0] instr_count;
  logic [10:0] ctl;
  int checks = 0;
  int failures = 0;
  logic ack_seen;
  control_unit dut (
    .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos), .in_valid(in_valid),
    .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr),
    .Aload(Aload), .Sub(Sub), .Asel(Asel), .in_ack(in_ack), .halted(halted),
    .state(state), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  // Control vector: IRload JMPmux PCload Meminst MemWr Aload Sub Asel[1:0] in_ack halted
  assign ctl = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, in_ack, halted};
  localparam logic [10:0] C_START  = 11'b00000000000;
  localparam logic [10:0] C_FETCH  = 11'b10100000000;
  localparam logic [10:0] C_EXEC   = 11'b00010000000;
  localparam logic [10:0] C_LOAD   = 11'b00010101000;
  localparam logic [10:0] C_STORE  = 11'b00011000000;
  localparam logic [10:0] C_ADD    = 11'b00010100000;
  localparam logic [10:0] C_INACK  = 11'b00010100110;
  localparam logic [10:0] C_JUMP   = 11'b01110000000;
  localparam logic [10:0] C_HALT   = 11'b00010000001;
  always @(posedge clk) if (in_ack) ack_seen <= 1'b1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    clear = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (state !== 4'd0 || instr_count !== 8'd0 || ctl !== C_START) begin
        failures++;
        $display("FAIL reset_hold state=%0d count=%0d ctl=%b want state=0 count=0 ctl=%b", state, instr_count, ctl, C_START);
      end
    end
    clear = 1'b0;
  endtask
  task automatic test_load_run();
    IR75 = 3'd0;
    tick();
    checks++;
    if (state !== 4'd1 || ctl !== C_FETCH || instr_count !== 8'd0) begin
      failures++;
      $display("FAIL load_fetch state=%0d ctl=%b count=%0d want 1 %b 0", state, ctl, instr_count, C_FETCH);
    end
    tick();
    checks++;
    if (state !== 4'd2 || ctl !== C_EXEC || instr_count !== 8'd1) begin
      failures++;
      $display("FAIL load_decode state=%0d ctl=%b count=%0d want 2 %b 1", state, ctl, instr_count, C_EXEC);
    end
    tick();
    checks++;
    if (state !== 4'd8 || ctl !== C_LOAD) begin
      failures++;
      $display("FAIL load_exec state=%0d ctl=%b want 8 %b", state, ctl, C_LOAD);
    end
    tick();
    checks++;
    if (state !== 4'd1 || ctl !== C_FETCH) begin
      failures++;
      $display("FAIL load_back state=%0d ctl=%b want 1 %b", state, ctl, C_FETCH);
    end
  endtask
  task automatic test_store();
    IR75 = 3'd1;
    tick();
    tick();
    checks++;
    if (state !== 4'd9 || ctl !== C_STORE) begin
      failures++;
      $display("FAIL store_exec state=%0d ctl=%b want 9 %b", state, ctl, C_STORE);
    end
    tick();
    checks++;
    if (state !== 4'd1 || MemWr !== 1'b0 || instr_count !== 8'd2) begin
      failures++;
      $display("FAIL store_after state=%0d MemWr=%b count=%0d want 1 0 2", state, MemWr, instr_count);
    end
  endtask
  task automatic test_jumps();
    logic [2:0]  ops [4] = '{3'd5, 3'd5, 3'd6, 3'd6};
    logic        zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        ps  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  sts [4] = '{4'd13, 4'd13, 4'd14, 4'd14};
    logic [10:0] exp [4] = '{C_JUMP, C_EXEC, C_EXEC, C_JUMP};
    for (int i = 0; i < 4; i++) begin
      IR75 = ops[i];
      tick();
      Aeq0 = zs[i];
      Apos = ps[i];
      tick();
      checks++;
      if (state !== sts[i] || ctl !== exp[i]) begin
        failures++;
        $display("FAIL jump_%0d state=%0d ctl=%b want %0d %b", i, state, ctl, sts[i], exp[i]);
      end
      tick();
      checks++;
      if (state !== 4'd1) begin
        failures++;
        $display("FAIL jump_back_%0d state=%0d want 1", i, state);
      end
    end
    Aeq0 = 1'b0;
    Apos = 1'b0;
  endtask
  task automatic test_input();
    IR75 = 3'd4;
    in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== 4'd12 || ctl !== C_EXEC) begin
        failures++;
        $display("FAIL input_wait_%0d state=%0d ctl=%b want 12 %b", i, state, ctl, C_EXEC);
      end
      tick();
    end
    in_valid = 1'b1;
    #1;
    checks++;
    if (state !== 4'd12 || ctl !== C_INACK) begin
      failures++;
      $display("FAIL input_ack state=%0d ctl=%b want 12 %b", state, ctl, C_INACK);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (state !== 4'd1 || in_ack !== 1'b0) begin
      failures++;
      $display("FAIL input_after state=%0d in_ack=%b want 1 0", state, in_ack);
    end
  endtask
  task automatic test_halt();
    IR75 = 3'd7;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (state !== 4'd15 || ctl !== C_HALT) begin
        failures++;
        $display("FAIL halt_hold_%0d state=%0d ctl=%b want 15 %b", i, state, ctl, C_HALT);
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (state !== 4'd0 || halted !== 1'b0 || instr_count !== 8'd0 || ctl !== C_START) begin
      failures++;
      $display("FAIL halt_clear state=%0d halted=%b count=%0d ctl=%b want 0 0 0 %b", state, halted, instr_count, ctl, C_START);
    end
  endtask
  task automatic test_clear_in_input();
    ack_seen = 1'b0;
    IR75 = 3'd4;
    tick();
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (state !== 4'd12) begin
      failures++;
      $display("FAIL clr_input_pre state=%0d want 12", state);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (state !== 4'd0 || instr_count !== 8'd0 || ack_seen !== 1'b0) begin
      failures++;
      $display("FAIL clr_input state=%0d count=%0d ack_seen=%b want 0 0 0", state, instr_count, ack_seen);
    end
  endtask
  task automatic test_wrap();
    logic sub_seen = 1'b0;
    logic bad_add = 1'b0;
    IR75 = 3'd2;
    tick();
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 254) begin
        checks++;
        if (instr_count !== 8'd255) begin
          failures++;
          $display("FAIL wrap_255 count=%0d want 255", instr_count);
        end
      end
      tick();
      if (Sub !== 1'b0) sub_seen = 1'b1;
      if (state !== 4'd10 || ctl !== C_ADD) bad_add = 1'b1;
      tick();
    end
    checks++;
    if (instr_count !== 8'd0 || state !== 4'd1) begin
      failures++;
      $display("FAIL wrap_zero count=%0d state=%0d want 0 1", instr_count, state);
    end
    checks++;
    if (sub_seen !== 1'b0 || bad_add !== 1'b0) begin
      failures++;
      $display("FAIL wrap_add sub_seen=%b bad_add=%b want 0 0", sub_seen, bad_add);
    end
  endtask
  initial begin
    test_reset();
    test_load_run();
    test_store();
    test_jumps();
    test_input();
    test_halt();
    test_clear_in_input();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
